embertrail_dmem_arbiter: RTL

- Two-requester arbiter and access sequencer for the Embertrail data-memory bus.
- Shares one address/data path between two requesters: requester 0 is the core load/store unit, requester 1 is the debug/DMA port.
- Drives the two data-memory banks' RW and bus-enable strobes and sequences a fixed-latency access.
- Returns a one-cycle acknowledge with read data to the requester that was granted.

---
 rtl/embertrail_pkg.sv | 17 +
 rtl/embertrail_rr_arb2.sv | 22 ++
 rtl/embertrail_dmem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/embertrail_pkg.sv
// Shared types and constants for the Embertrail data-memory arbiter.
// Holds the sequencer state encoding, bank RW encoding and requester IDs.
package embertrail_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/embertrail_rr_arb2.sv
// Combinational 2-way round-robin picker: one-hot grant plus valid, zero latency.
// On contention, the requester not granted last wins; the pointer is held by the parent.
module embertrail_rr_arb2 (
  input  logic [1:0] req,
  input  logic       lastGnt,
  output logic [1:0] gnt,
  output logic       vld
);
  import embertrail_pkg::*;

  always_comb begin
    gnt = 2'b00;
    vld = |req;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (lastGnt == REQ_CORE) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/embertrail_dmem_arbiter.sv
// Two-requester data-memory arbiter: grant 1 cycle after request, bank enable for MEM_LAT cycles, ack at MEM_LAT+1.
// Requests are ignored while an access is in flight; acceptance in DONE allows back-to-back accesses.
module embertrail_dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int BANK_SEL_BIT = 15
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iReq0,
  input  logic              iWe0,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [DATA_W-1:0] iWData0,
  output logic              oGnt0,
  output logic              oAck0,
  output logic [DATA_W-1:0] oRData0,
  input  logic              iReq1,
  input  logic              iWe1,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWData1,
  output logic              oGnt1,
  output logic              oAck1,
  output logic [DATA_W-1:0] oRData1,
  output logic [ADDR_W-1:0] oDataAddrBus,
  output logic [DATA_W-1:0] oDataWrBus,
  input  logic [DATA_W-1:0] iDataDataBus,
  output logic              oDataMem1RW,
  output logic              oDataMem2RW,
  output logic              oData1BusEn,
  output logic              oData2BusEn,
  output logic              oBusy
);
  import embertrail_pkg::*;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t            state;
  logic [3:0]        latCnt;
  logic              lastGnt;
  logic              curWe;

  logic [1:0]        reqVec;
  logic [1:0]        gntVec;
  logic              gntVld;
  logic              selId;
  logic              selWe;
  logic              selBank;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWData;

  assign reqVec = {iReq1, iReq0};

  embertrail_rr_arb2 uArb (
    .req     (reqVec),
    .lastGnt (lastGnt),
    .gnt     (gntVec),
    .vld     (gntVld)
  );

  assign selId    = gntVec[1] ? REQ_DBG : REQ_CORE;
  assign selWe    = gntVec[1] ? iWe1    : iWe0;
  assign selAddr  = gntVec[1] ? iAddr1  : iAddr0;
  assign selWData = gntVec[1] ? iWData1 : iWData0;
  assign selBank  = selAddr[BANK_SEL_BIT];

  // lastGnt doubles as the ID of the access in flight, since it is written on every grant.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state        <= IDLE;
      latCnt       <= '0;
      lastGnt      <= REQ_DBG;
      curWe        <= RW_READ;
      oGnt0        <= 1'b0;
      oGnt1        <= 1'b0;
      oAck0        <= 1'b0;
      oAck1        <= 1'b0;
      oRData0      <= '0;
      oRData1      <= '0;
      oDataAddrBus <= '0;
      oDataWrBus   <= '0;
      oDataMem1RW  <= 1'b0;
      oDataMem2RW  <= 1'b0;
      oData1BusEn  <= 1'b0;
      oData2BusEn  <= 1'b0;
      oBusy        <= 1'b0;
    end else begin
      oGnt0 <= 1'b0;
      oGnt1 <= 1'b0;
      oAck0 <= 1'b0;
      oAck1 <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (gntVld) begin
            state        <= ACCESS;
            latCnt       <= LAT_INIT;
            lastGnt      <= selId;
            curWe        <= selWe;
            oDataAddrBus <= selAddr;
            oDataWrBus   <= selWData;
            oGnt0        <= gntVec[0];
            oGnt1        <= gntVec[1];
            oData1BusEn  <= ~selBank;
            oData2BusEn  <= selBank;
            oDataMem1RW  <= ~selBank & selWe;
            oDataMem2RW  <= selBank & selWe;
            oBusy        <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (latCnt == 4'd1) begin
            state       <= DONE;
            oData1BusEn <= 1'b0;
            oData2BusEn <= 1'b0;
            oDataMem1RW <= 1'b0;
            oDataMem2RW <= 1'b0;
            oBusy       <= 1'b0;
            oAck0       <= (lastGnt == REQ_CORE);
            oAck1       <= (lastGnt == REQ_DBG);
            if (curWe == RW_READ) begin
              if (lastGnt == REQ_DBG) oRData1 <= iDataDataBus;
              else                    oRData0 <= iDataDataBus;
            end
          end else begin
            latCnt <= latCnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
